mpx_muldiv_seq: RTL and testbench

- Parametrised, multi-cycle integer multiply/divide unit for the MPX core; the sequential successor to the single-cycle combinational ALU.
- Executes MULT/MULTU/DIV/DIVU into architectural HI/LO registers. Also handles MTHI/MTLO writes.
- Sits beside the ALU in the execute stage. The pipeline issues through a valid/ready handshake, stalls on busy_o, and flushes via abort_i on exceptions.

---
 rtl/mpx_muldiv_seq.sv | 182 ++++++++++++++++++
 tb/tb_mpx_muldiv_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpx_muldiv_seq.sv
// Multi-cycle integer multiply/divide unit: shift-add multiply, restoring divide,
// results into architectural HI/LO with a valid/ready issue handshake.
module mpx_muldiv_seq #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             abort_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH / MUL_BITS - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic signed [WIDTH-1:0] ZERO_S = '0;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return '0 - x;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return '0 - x;
    endfunction

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 is_div;
    logic                 neg_res;
    logic                 neg_rem;
    logic [WIDTH-1:0]     opnd;
    logic [2*WIDTH-1:0]   acc;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic                    signed_op;
    logic                    a_neg;
    logic                    b_neg;
    logic                    accept_md;
    logic [WIDTH-1:0]        a_mag;
    logic [WIDTH-1:0]        b_mag;

    assign a_s     = a_i;
    assign b_s     = b_i;
    assign ready_o = (state == IDLE);
    assign busy_o  = !ready_o;

    always_comb begin
        signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
        a_neg     = signed_op && (a_s < ZERO_S);
        b_neg     = signed_op && (b_s < ZERO_S);
        a_mag     = a_neg ? neg_w(a_i) : a_i;
        b_mag     = b_neg ? neg_w(b_i) : b_i;
        accept_md = (state == IDLE) && valid_i && !abort_i && (op_i <= OP_DIVU);
    end

    // Multiply step: acc = {partial product, unretired multiplier bits}
    logic [WIDTH+MUL_BITS-1:0] mul_sum;
    logic [2*WIDTH-1:0]        mul_next;

    always_comb begin
        mul_sum = {{MUL_BITS{1'b0}}, acc[2*WIDTH-1:WIDTH]};
        for (int j = 0; j < MUL_BITS; j++) begin
            if (acc[j]) begin
                mul_sum = mul_sum + ({{MUL_BITS{1'b0}}, opnd} << j);
            end
        end
        mul_next = {mul_sum, acc[WIDTH-1:MUL_BITS]};
    end

    // Divide step: acc = {partial remainder, dividend bits shifting into quotient}
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        div_next  = {div_ge ? div_diff : div_shift[WIDTH-1:0], acc[WIDTH-2:0], div_ge};
    end

    // Sign fix-up applied on the FIX edge
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   quo_res;
    logic [WIDTH-1:0]   rem_res;

    always_comb begin
        mul_res = neg_res ? neg_2w(acc) : acc;
        quo_res = neg_res ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_res = neg_rem ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk_i) begin
        if (accept_md) begin
            if (op_i[1]) begin
                acc  <= {{WIDTH{1'b0}}, a_mag};
                opnd <= b_mag;
            end else begin
                acc  <= {{WIDTH{1'b0}}, b_mag};
                opnd <= a_mag;
            end
        end else if (state == RUN) begin
            acc <= is_div ? div_next : mul_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i && !abort_i) begin
                        case (op_i)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                state   <= RUN;
                                is_div  <= op_i[1];
                                cnt     <= op_i[1] ? DIV_LAST : MUL_LAST;
                                neg_res <= a_neg ^ b_neg;
                                neg_rem <= a_neg;
                            end
                            OP_MTHI: hi_o <= a_i;
                            OP_MTLO: lo_o <= a_i;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!abort_i) begin
                        done_o <= 1'b1;
                        if (is_div) begin
                            lo_o <= quo_res;
                            hi_o <= rem_res;
                        end else begin
                            {hi_o, lo_o} <= mul_res;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpx_muldiv_seq.sv
// Directed and model-checked bench for mpx_muldiv_seq at WIDTH=32/MUL_BITS=1
// and WIDTH=16/MUL_BITS=4.
module tb_mpx_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, abort;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        ready, busy, done;
    logic [31:0] hi, lo;

    logic        v16, abort16;
    logic [2:0]  op16;
    logic [15:0] a16, b16;
    logic        ready16, busy16, done16;
    logic [15:0] hi16, lo16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mpx_muldiv_seq #(.WIDTH(32), .MUL_BITS(1)) u_dut (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .op_i(op), .a_i(a), .b_i(b),
        .abort_i(abort), .ready_o(ready), .busy_o(busy), .done_o(done),
        .hi_o(hi), .lo_o(lo)
    );

    mpx_muldiv_seq #(.WIDTH(16), .MUL_BITS(4)) u_dut16 (
        .clk_i(clk), .rst_i(rst_n), .valid_i(v16), .op_i(op16), .a_i(a16), .b_i(b16),
        .abort_i(abort16), .ready_o(ready16), .busy_o(busy16), .done_o(done16),
        .hi_o(hi16), .lo_o(lo16)
    );

    // Issue one op; returns at the first falling edge after the accept edge.
    task automatic issue32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        valid = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Edges from accept to the edge that raised done, or -1 on timeout.
    task automatic wait_done32(output int edges);
        edges = -1;
        for (int k = 1; k <= 100; k++) begin
            if (done) begin
                edges = k - 1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic run32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int edges);
        issue32(o, x, y);
        wait_done32(edges);
    endtask

    task automatic issue16(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        v16 = 1'b1; op16 = o; a16 = x; b16 = y;
        @(negedge clk);
        v16 = 1'b0;
    endtask

    task automatic wait_done16(output int edges);
        edges = -1;
        for (int k = 1; k <= 100; k++) begin
            if (done16) begin
                edges = k - 1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi got %h want %h", hi, 32'h0); end
        tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo got %h want %h", lo, 32'h0); end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (ready !== 1'b1 || hi !== 32'h0) begin fails++; $display("FAIL idle_after_reset got ready=%b hi=%h want 1/0", ready, hi); end
    endtask

    task automatic test_mult;
        int e;
        issue32(3'd0, 32'hFFFF_FFFE, 32'd3);
        tests++; if (busy !== 1'b1 || ready !== 1'b0) begin fails++; $display("FAIL mult_busy got busy=%b ready=%b want 1/0", busy, ready); end
        tests++; if (hi !== 32'h0 || lo !== 32'h0) begin fails++; $display("FAIL mult_hold got %h_%h want 0_0", hi, lo); end
        wait_done32(e);
        tests++; if (e !== 33) begin fails++; $display("FAIL mult_latency got %0d want 33", e); end
        tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        tests++; if (lo !== 32'hFFFF_FFFA) begin fails++; $display("FAIL mult_lo got %h want fffffffa", lo); end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL mult_ready_with_done got %b want 1", ready); end
        @(negedge clk);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL done_one_cycle got %b want 0", done); end
        run32(3'd1, 32'hFFFF_FFFE, 32'd3, e);
        tests++; if (e !== 33) begin fails++; $display("FAIL multu_latency got %0d want 33", e); end
        tests++; if (hi !== 32'h0000_0002) begin fails++; $display("FAIL multu_hi got %h want 00000002", hi); end
        tests++; if (lo !== 32'hFFFF_FFFA) begin fails++; $display("FAIL multu_lo got %h want fffffffa", lo); end
    endtask

    task automatic test_div;
        int e;
        run32(3'd2, 32'hFFFF_FFF9, 32'd2, e);
        tests++; if (e !== 33) begin fails++; $display("FAIL div_latency got %0d want 33", e); end
        tests++; if (lo !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_lo got %h want fffffffd", lo); end
        tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_hi got %h want ffffffff", hi); end
        run32(3'd3, 32'd7, 32'd0, e);
        tests++; if (e !== 33) begin fails++; $display("FAIL divu0_latency got %0d want 33", e); end
        tests++; if (lo !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divu0_lo got %h want ffffffff", lo); end
        tests++; if (hi !== 32'd7) begin fails++; $display("FAIL divu0_hi got %h want 00000007", hi); end
        run32(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, e);
        tests++; if (lo !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL div_ovf_hi got %h want 00000000", hi); end
        run32(3'd2, 32'hFFFF_FFFB, 32'd0, e);
        tests++; if (lo !== 32'h1) begin fails++; $display("FAIL div0_neg_lo got %h want 00000001", lo); end
        tests++; if (hi !== 32'hFFFF_FFFB) begin fails++; $display("FAIL div0_neg_hi got %h want fffffffb", hi); end
        run32(3'd2, 32'd100, 32'hFFFF_FFF9, e);
        tests++; if (lo !== 32'hFFFF_FFF2 || hi !== 32'd2) begin fails++; $display("FAIL div_neg_divisor got %h_%h want 00000002_fffffff2", hi, lo); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        valid = 1'b1; op = 3'd4; a = 32'h1234_5678;
        @(negedge clk);
        tests++; if (hi !== 32'h1234_5678) begin fails++; $display("FAIL mthi got %h want 12345678", hi); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mthi_busy got %b want 0", busy); end
        op = 3'd5; a = 32'h9ABC_DEF0;
        @(negedge clk);
        tests++; if (lo !== 32'h9ABC_DEF0) begin fails++; $display("FAIL mtlo got %h want 9abcdef0", lo); end
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL mtlo_busy_done got %b/%b want 0/0", busy, done); end
        op = 3'd6; a = 32'hDEAD_BEEF; b = 32'h1;
        @(negedge clk);
        valid = 1'b0;
        tests++; if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0 || busy !== 1'b0) begin
            fails++; $display("FAIL reserved_op got %h_%h busy=%b want 12345678_9abcdef0 busy=0", hi, lo, busy);
        end
    endtask

    task automatic test_valid_held;
        int k;
        @(negedge clk);
        valid = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(negedge clk);
        op = 3'd4; a = 32'hCAFE_BABE;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL held_busy got %b want 1", busy); end
        repeat (19) @(negedge clk);
        tests++; if (hi !== 32'h1234_5678 || busy !== 1'b1) begin fails++; $display("FAIL held_ignored got %h busy=%b want 12345678 busy=1", hi, busy); end
        k = 20;
        while (!ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        tests++; if (k !== 34) begin fails++; $display("FAIL held_ready_cycle got %0d want 34", k); end
        tests++; if (done !== 1'b1 || hi !== 32'd2 || lo !== 32'd14) begin
            fails++; $display("FAIL held_div got done=%b %h_%h want 1 00000002_0000000e", done, hi, lo);
        end
        @(negedge clk);
        valid = 1'b0;
        tests++; if (hi !== 32'hCAFE_BABE || lo !== 32'd14) begin fails++; $display("FAIL held_accept got %h_%h want cafebabe_0000000e", hi, lo); end
    endtask

    task automatic test_abort;
        int seen;
        issue32(3'd2, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests++; if (ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL abort_idle got ready=%b busy=%b want 1/0", ready, busy); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
        tests++; if (hi !== 32'hCAFE_BABE || lo !== 32'd14) begin fails++; $display("FAIL abort_hilo got %h_%h want cafebabe_0000000e", hi, lo); end
        @(negedge clk);
        valid = 1'b1; op = 3'd4; a = 32'h1111_1111; abort = 1'b1;
        @(negedge clk);
        valid = 1'b0; abort = 1'b0;
        tests++; if (hi !== 32'hCAFE_BABE) begin fails++; $display("FAIL abort_priority got %h want cafebabe", hi); end
    endtask

    task automatic test_reset_mid;
        int seen;
        issue32(3'd0, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if (ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL rst_mid_state got ready=%b busy=%b want 1/0", ready, busy); end
        tests++; if (hi !== 32'h0 || lo !== 32'h0) begin fails++; $display("FAIL rst_mid_hilo got %h_%h want 0_0", hi, lo); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) seen++;
        end
        tests++; if (seen !== 0 || lo !== 32'h0) begin fails++; $display("FAIL rst_mid_no_result got %0d pulses lo=%h want 0/0", seen, lo); end
    endtask

    task automatic test_w16;
        int e;
        issue16(3'd0, 16'h8000, 16'h8000);
        wait_done16(e);
        tests++; if (e !== 5) begin fails++; $display("FAIL w16_mult_latency got %0d want 5", e); end
        tests++; if (hi16 !== 16'h4000 || lo16 !== 16'h0000) begin fails++; $display("FAIL w16_mult got %h_%h want 4000_0000", hi16, lo16); end
        issue16(3'd1, 16'hFFFF, 16'hFFFF);
        wait_done16(e);
        tests++; if (hi16 !== 16'hFFFE || lo16 !== 16'h0001) begin fails++; $display("FAIL w16_multu got %h_%h want fffe_0001", hi16, lo16); end
        issue16(3'd2, 16'hFFF9, 16'h0002);
        wait_done16(e);
        tests++; if (e !== 17) begin fails++; $display("FAIL w16_div_latency got %0d want 17", e); end
        tests++; if (hi16 !== 16'hFFFF || lo16 !== 16'hFFFD) begin fails++; $display("FAIL w16_div got %h_%h want ffff_fffd", hi16, lo16); end
    endtask

    function automatic logic [15:0] pick16(input int sel, input logic [15:0] r);
        case (sel)
            0: return 16'h8000;
            1: return 16'hFFFF;
            2: return 16'h0000;
            3: return 16'h0001;
            default: return r;
        endcase
    endfunction

    task automatic test_random16;
        logic [15:0] x, y, mhi, mlo, ehi, elo;
        logic signed [15:0] sx, sy;
        logic signed [31:0] ps;
        logic [31:0] pu;
        logic [2:0]  o;
        int e, exp_e;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mhi = '0;
        mlo = '0;
        for (int n = 0; n < 300; n++) begin
            o  = 3'($urandom_range(0, 7));
            x  = pick16($urandom_range(0, 9), 16'($urandom));
            y  = pick16($urandom_range(0, 9), 16'($urandom));
            sx = x;
            sy = y;
            ehi = mhi;
            elo = mlo;
            exp_e = 5;
            case (o)
                3'd0: begin ps = sx * sy; {ehi, elo} = ps; end
                3'd1: begin pu = x * y; {ehi, elo} = pu; end
                3'd2: begin
                    exp_e = 17;
                    if (y == 16'h0) begin elo = x[15] ? 16'h0001 : 16'hFFFF; ehi = x; end
                    else if (x == 16'h8000 && y == 16'hFFFF) begin elo = 16'h8000; ehi = 16'h0; end
                    else begin elo = sx / sy; ehi = sx % sy; end
                end
                3'd3: begin
                    exp_e = 17;
                    if (y == 16'h0) begin elo = 16'hFFFF; ehi = x; end
                    else begin elo = x / y; ehi = x % y; end
                end
                3'd4: ehi = x;
                3'd5: elo = x;
                default: ;
            endcase
            mhi = ehi;
            mlo = elo;
            issue16(o, x, y);
            if (o <= 3'd3) begin
                wait_done16(e);
                tests++; if (e !== exp_e) begin fails++; $display("FAIL rnd_latency op=%0d got %0d want %0d", o, e, exp_e); end
            end else begin
                tests++; if (busy16 !== 1'b0) begin fails++; $display("FAIL rnd_busy op=%0d got %b want 0", o, busy16); end
            end
            tests++; if (hi16 !== ehi || lo16 !== elo) begin
                fails++; $display("FAIL rnd_result op=%0d a=%h b=%h got %h_%h want %h_%h", o, x, y, hi16, lo16, ehi, elo);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; abort = 1'b0; op = '0; a = '0; b = '0;
        v16 = 1'b0; abort16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
        test_reset();
        test_mult();
        test_div();
        test_back_to_back();
        test_valid_held();
        test_abort();
        test_reset_mid();
        test_w16();
        test_random16();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
